mem_access_unit: RTL and testbench

Memory access unit sitting directly downstream of the Argon core's memory port. It takes one byte, halfword or word load/store request at a time and turns it into a single access on a 32-bit synchronous RAM with byte enables. It returns load data formatted (lane-selected, sign- or zero-extended) with a one-cycle response strobe. It also checks alignment and reports misaligned requests as faults without touching the RAM.

---
 rtl/mem_access_unit.sv | 198 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Turns one byte/half/word load or store request from the core into a
// single access on a 32-bit synchronous RAM with byte enables, and returns
// formatted load data with a one-cycle response strobe. Misaligned or
// illegal requests get a fault response and never touch the RAM.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request
// ACCESS | RAM strobe (o_ram_en) high for this one cycle
// WAIT   | load in flight; counting down RAM read latency
// RESP   | o_rsp_valid high for one cycle; data/fault valid
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_req_*/o_req_ready     request handshake (addr, store data, masks)
//   o_rsp_*                 response strobe, load data, fault flag
//   o_ram_*/i_ram_rd_data   synchronous RAM port (word address, byte enables)
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W     = 14,
    parameter int RD_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wr_data,
    input  logic [2:0]        i_req_rd_mask,
    input  logic [1:0]        i_req_wr_mask,
    output logic              o_rsp_valid,
    output logic [31:0]       o_rsp_rd_data,
    output logic              o_rsp_fault,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [3:0]        o_ram_be,
    output logic [31:0]       o_ram_wr_data,
    input  logic [31:0]       i_ram_rd_data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [2:0] WAIT_INIT = 3'(RD_LATENCY - 1);

    logic [1:0]  state;
    logic [2:0]  rd_mask_q;
    logic [1:0]  lane_q;
    logic [2:0]  wait_cnt;

    logic        accept;
    logic        is_half;
    logic        is_word;
    logic        illegal;
    logic        is_noop;
    logic        is_store;
    logic [3:0]  store_be;
    logic [31:0] store_data;
    logic [31:0] rd_shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_fmt;

    // Address bits above the RAM size are deliberately dropped (wraparound).
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_req_addr[31:ADDR_W+2];

    assign o_req_ready = (state == ST_IDLE) & ~i_reset;
    assign accept      = i_req_valid & o_req_ready;

    always_comb begin
        is_half  = (i_req_rd_mask[1:0] == 2'b10) | (i_req_wr_mask == 2'b10);
        is_word  = (i_req_rd_mask[1:0] == 2'b11) | (i_req_wr_mask == 2'b11);
        illegal  = ((|i_req_rd_mask) & (|i_req_wr_mask))
                 | (i_req_rd_mask == 3'b100) | (i_req_rd_mask == 3'b111)
                 | (is_half & i_req_addr[0])
                 | (is_word & (|i_req_addr[1:0]));
        is_noop  = (i_req_rd_mask == 3'b000) & (i_req_wr_mask == 2'b00);
        is_store = |i_req_wr_mask;
    end

    // Store data is replicated across lanes so the byte enables alone pick
    // the destination bytes.
    always_comb begin
        store_be   = 4'b0000;
        store_data = 32'h0;
        case (i_req_wr_mask)
            2'b01: begin
                store_be   = 4'b0001 << i_req_addr[1:0];
                store_data = {4{i_req_wr_data[7:0]}};
            end
            2'b10: begin
                store_be   = i_req_addr[1] ? 4'b1100 : 4'b0011;
                store_data = {2{i_req_wr_data[15:0]}};
            end
            2'b11: begin
                store_be   = 4'b1111;
                store_data = i_req_wr_data;
            end
            default: begin
                store_be   = 4'b0000;
                store_data = 32'h0;
            end
        endcase
    end

    always_comb begin
        rd_shifted = i_ram_rd_data >> {lane_q, 3'b000};
        byte_sel   = rd_shifted[7:0];
        half_sel   = lane_q[1] ? i_ram_rd_data[31:16] : i_ram_rd_data[15:0];
        case (rd_mask_q)
            3'b001:  load_fmt = {24'h0, byte_sel};
            3'b101:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b010:  load_fmt = {16'h0, half_sel};
            3'b110:  load_fmt = {{16{half_sel[15]}}, half_sel};
            default: load_fmt = i_ram_rd_data;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= ST_IDLE;
            rd_mask_q     <= 3'b000;
            lane_q        <= 2'b00;
            wait_cnt      <= 3'd0;
            o_rsp_valid   <= 1'b0;
            o_rsp_rd_data <= 32'h0;
            o_rsp_fault   <= 1'b0;
            o_ram_en      <= 1'b0;
            o_ram_we      <= 1'b0;
            o_ram_addr    <= '0;
            o_ram_be      <= 4'b0000;
            o_ram_wr_data <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        rd_mask_q <= i_req_rd_mask;
                        lane_q    <= i_req_addr[1:0];
                        if (illegal) begin
                            state       <= ST_RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_fault <= 1'b1;
                        end else if (is_noop) begin
                            state       <= ST_RESP;
                            o_rsp_valid <= 1'b1;
                        end else begin
                            state         <= ST_ACCESS;
                            o_ram_en      <= 1'b1;
                            o_ram_we      <= is_store;
                            o_ram_addr    <= i_req_addr[ADDR_W+1:2];
                            o_ram_be      <= is_store ? store_be : 4'b1111;
                            o_ram_wr_data <= is_store ? store_data : 32'h0;
                        end
                    end
                end
                ST_ACCESS: begin
                    o_ram_en      <= 1'b0;
                    o_ram_we      <= 1'b0;
                    o_ram_addr    <= '0;
                    o_ram_be      <= 4'b0000;
                    o_ram_wr_data <= 32'h0;
                    // o_ram_we still holds the store flag for this access.
                    if (o_ram_we) begin
                        state       <= ST_RESP;
                        o_rsp_valid <= 1'b1;
                    end else begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state         <= ST_RESP;
                        o_rsp_valid   <= 1'b1;
                        o_rsp_rd_data <= load_fmt;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_RESP: begin
                    state         <= ST_IDLE;
                    o_rsp_valid   <= 1'b0;
                    o_rsp_fault   <= 1'b0;
                    o_rsp_rd_data <= 32'h0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        reset3;
    logic        req_valid;
    logic        req_valid3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_rmask;
    logic [1:0]  req_wmask;

    logic        ready,  ready3;
    logic        rsp_valid, rsp_valid3;
    logic [31:0] rsp_data,  rsp_data3;
    logic        rsp_fault, rsp_fault3;
    logic        ram_en,  ram_en3;
    logic        ram_we,  ram_we3;
    logic [13:0] ram_addr, ram_addr3;
    logic [3:0]  ram_be,  ram_be3;
    logic [31:0] ram_wdata, ram_wdata3;
    logic [31:0] ram_rdata;
    logic [31:0] ram_rdata3;

    int pass_cnt = 0;
    int total    = 0;

    logic [31:0] mem [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(14), .RD_LATENCY(1)) dut (
        .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .o_req_ready(ready),
        .i_req_addr(req_addr), .i_req_wr_data(req_wdata), .i_req_rd_mask(req_rmask),
        .i_req_wr_mask(req_wmask), .o_rsp_valid(rsp_valid), .o_rsp_rd_data(rsp_data),
        .o_rsp_fault(rsp_fault), .o_ram_en(ram_en), .o_ram_we(ram_we),
        .o_ram_addr(ram_addr), .o_ram_be(ram_be), .o_ram_wr_data(ram_wdata),
        .i_ram_rd_data(ram_rdata)
    );

    mem_access_unit #(.ADDR_W(14), .RD_LATENCY(3)) dut3 (
        .i_clk(clk), .i_reset(reset3), .i_req_valid(req_valid3), .o_req_ready(ready3),
        .i_req_addr(req_addr), .i_req_wr_data(req_wdata), .i_req_rd_mask(req_rmask),
        .i_req_wr_mask(req_wmask), .o_rsp_valid(rsp_valid3), .o_rsp_rd_data(rsp_data3),
        .o_rsp_fault(rsp_fault3), .o_ram_en(ram_en3), .o_ram_we(ram_we3),
        .o_ram_addr(ram_addr3), .o_ram_be(ram_be3), .o_ram_wr_data(ram_wdata3),
        .i_ram_rd_data(ram_rdata3)
    );

    // Latency-1 RAM model for dut.
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= mem[ram_addr[3:0]];
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[3:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    // dut3 only needs a fixed read word; its latency counter is what matters.
    assign ram_rdata3 = 32'hCAFEF00D;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] rm, input logic [1:0] wm);
        @(negedge clk);
        req_addr  = a;
        req_wdata = d;
        req_rmask = rm;
        req_wmask = wm;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        reset3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({ready, rsp_valid, rsp_fault, ram_en, ram_we} !== 5'b0 ||
            rsp_data !== 32'h0 || ram_addr !== 14'h0 || ram_be !== 4'h0 || ram_wdata !== 32'h0)
            $display("FAIL reset_outputs: ready=%b rsp_valid=%b en=%b be=%h want all zero",
                     ready, rsp_valid, ram_en, ram_be);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        reset3 = 1'b0;
        #1;
        total++;
        if (ready !== 1'b1 || ready3 !== 1'b1)
            $display("FAIL reset_release_ready: got %b/%b want 1/1", ready, ready3);
        else pass_cnt++;
    endtask

    task automatic test_store(input string nm, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] wm, input logic [13:0] exp_addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd);
        issue(a, d, 3'b000, wm);
        total++;
        if ({ram_en, ram_we} !== 2'b11 || ram_addr !== exp_addr || ram_be !== exp_be ||
            ram_wdata !== exp_wd || rsp_valid !== 1'b0)
            $display("FAIL %s_c1: en=%b we=%b addr=%h be=%b wd=%h want 1 1 %h %b %h",
                     nm, ram_en, ram_we, ram_addr, ram_be, ram_wdata, exp_addr, exp_be, exp_wd);
        else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if ({rsp_valid, rsp_fault, ram_en} !== 3'b100 || rsp_data !== 32'h0)
            $display("FAIL %s_c2_rsp: valid=%b fault=%b en=%b data=%h want 1 0 0 0",
                     nm, rsp_valid, rsp_fault, ram_en, rsp_data);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_load(input string nm, input logic [31:0] a, input logic [2:0] rm,
                             input logic [31:0] exp);
        int c;
        bit found;
        issue(a, 32'h0, rm, 2'b00);
        total++;
        if ({ram_en, ram_we} !== 2'b10 || ram_be !== 4'b1111 || ram_addr !== a[15:2])
            $display("FAIL %s_c1: en=%b we=%b be=%b addr=%h want 1 0 1111 %h",
                     nm, ram_en, ram_we, ram_be, ram_addr, a[15:2]);
        else pass_cnt++;
        c = 1;
        found = 0;
        while (c < 10 && !found) begin
            @(posedge clk); #1;
            c++;
            if (rsp_valid) found = 1;
        end
        total++;
        if (!found || c != 3 || rsp_data !== exp || rsp_fault !== 1'b0)
            $display("FAIL %s_rsp: found=%0d cycle=C%0d data=%h fault=%b want C3 %h 0",
                     nm, found, c, rsp_data, rsp_fault, exp);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_fault(input string nm, input logic [31:0] a, input logic [2:0] rm,
                              input logic [1:0] wm, input logic exp_fault);
        issue(a, 32'h1234_5678, rm, wm);
        total++;
        if ({rsp_valid, rsp_fault, ram_en} !== {1'b1, exp_fault, 1'b0} || rsp_data !== 32'h0)
            $display("FAIL %s_c1: valid=%b fault=%b en=%b data=%h want 1 %b 0 0",
                     nm, rsp_valid, rsp_fault, ram_en, rsp_data, exp_fault);
        else pass_cnt++;
        @(posedge clk); #1;
        total++;
        if ({ready, rsp_valid, rsp_fault, ram_en} !== 4'b1000)
            $display("FAIL %s_c2: ready=%b valid=%b fault=%b en=%b want 1 0 0 0",
                     nm, ready, rsp_valid, rsp_fault, ram_en);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int acc[4];
        int n;
        n = 0;
        @(negedge clk);
        req_addr  = 32'h20;
        req_wdata = 32'hA5A5_5A5A;
        req_rmask = 3'b000;
        req_wmask = 2'b11;
        req_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (ready && n < 4) begin
                acc[n] = c;
                n++;
            end
            @(posedge clk);
            @(negedge clk);
            if (n == 4) begin
                req_valid = 1'b0;
                break;
            end
        end
        req_valid = 1'b0;
        total++;
        if (n != 4 || acc[0] != 0 || acc[1] != 3 || acc[2] != 6 || acc[3] != 9)
            $display("FAIL back_to_back_accepts: n=%0d edges=%0d,%0d,%0d,%0d want 0,3,6,9",
                     n, acc[0], acc[1], acc[2], acc[3]);
        else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (ready !== 1'b1 || mem[8] !== 32'hA5A5_5A5A)
            $display("FAIL back_to_back_drain: ready=%b mem=%h want 1 a5a55a5a", ready, mem[8]);
        else pass_cnt++;
    endtask

    task automatic test_latency3();
        int c;
        bit found;
        @(negedge clk);
        req_addr   = 32'h12;
        req_rmask  = 3'b110;
        req_wmask  = 2'b00;
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        c = 1;
        found = 0;
        while (c < 12 && !found) begin
            @(posedge clk); #1;
            c++;
            if (rsp_valid3) found = 1;
        end
        total++;
        if (!found || c != 5 || rsp_data3 !== 32'hFFFF_CAFE)
            $display("FAIL lat3_load: found=%0d cycle=C%0d data=%h want C5 ffffcafe",
                     found, c, rsp_data3);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_load();
        int seen;
        @(negedge clk);
        req_addr   = 32'h10;
        req_rmask  = 3'b011;
        req_wmask  = 2'b00;
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        total++;
        if (ram_en3 !== 1'b1)
            $display("FAIL rst_mid_c1_en: got %b want 1", ram_en3);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        reset3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset3 = 1'b0;
        #1;
        total++;
        if (ready3 !== 1'b1 || rsp_valid3 !== 1'b0)
            $display("FAIL rst_mid_ready: ready=%b rsp_valid=%b want 1 0", ready3, rsp_valid3);
        else pass_cnt++;
        seen = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rsp_valid3) seen++;
        end
        total++;
        if (seen != 0)
            $display("FAIL rst_mid_no_rsp: %0d responses seen want 0", seen);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        req_valid  = 1'b0;
        req_valid3 = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rmask  = 3'b000;
        req_wmask  = 2'b00;

        test_reset();
        test_store("st_word", 32'h10, 32'hDEAD_BEEF, 2'b11, 14'd4, 4'b1111, 32'hDEAD_BEEF);
        test_load("ld_word", 32'h10, 3'b011, 32'hDEAD_BEEF);
        test_store("st_byte", 32'h13, 32'h0000_0080, 2'b01, 14'd4, 4'b1000, 32'h8080_8080);
        test_load("ld_sbyte13", 32'h13, 3'b101, 32'hFFFF_FF80);
        test_load("ld_ubyte13", 32'h13, 3'b001, 32'h0000_0080);
        test_store("st_word2", 32'h10, 32'hDEAD_BEEF, 2'b11, 14'd4, 4'b1111, 32'hDEAD_BEEF);
        test_load("ld_shalf12", 32'h12, 3'b110, 32'hFFFF_DEAD);
        test_load("ld_uhalf10", 32'h10, 3'b010, 32'h0000_BEEF);
        test_load("ld_sbyte11", 32'h11, 3'b101, 32'hFFFF_FFBE);
        test_store("st_half16", 32'h16, 32'h0000_1234, 2'b10, 14'd5, 4'b1100, 32'h1234_1234);
        test_load("ld_word14", 32'h14, 3'b011, 32'h1234_0000);
        test_fault("f_word_ld11", 32'h11, 3'b011, 2'b00, 1'b1);
        test_fault("f_half_st13", 32'h13, 3'b000, 2'b10, 1'b1);
        test_fault("f_both_masks", 32'h10, 3'b011, 2'b11, 1'b1);
        test_fault("f_rmask100", 32'h10, 3'b100, 2'b00, 1'b1);
        test_fault("noop", 32'h10, 3'b000, 2'b00, 1'b0);
        test_back_to_back();
        test_latency3();
        test_reset_mid_load();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
